// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: byte-granular instruction prefetch queue presenting a decode window
module instr_prefetch_queue #(
  parameter int          DEPTH_BYTES = 16,
  parameter int          WIN_BYTES   = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  output logic                   o_mem_req,
  output logic [31:0]            o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [31:0]            i_mem_data,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_addr,
  output logic [8*WIN_BYTES-1:0] o_window,
  output logic [3:0]             o_win_bytes,
  output logic [31:0]            o_win_pc,
  input  logic                   i_consume,
  input  logic [3:0]             i_consume_bytes
);
  localparam int PW = $clog2(DEPTH_BYTES);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
  state_t        state, state_n;
  logic [7:0]    q [DEPTH_BYTES];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_n, win_n, want, cons, acc_n;
  logic [1:0]    skip;
  logic          acc;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    o_mem_req   = state == FETCH;
    acc         = o_mem_req && i_mem_ack && !i_redirect;
    win_n       = count > CW'(WIN_BYTES) ? CW'(WIN_BYTES) : count;
    want        = CW'(i_consume_bytes);
    cons        = (i_consume && !i_redirect) ? (want > win_n ? win_n : want) : '0;
    acc_n       = acc ? CW'(3'd4 - {1'b0, skip}) : '0;
    count_n     = i_redirect ? '0 : count + acc_n - cons;
    state_n     = count_n <= CW'(DEPTH_BYTES - 4) ? FETCH : FULL;
    o_win_bytes = 4'(win_n);
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      skip       <= RESET_PC[1:0];
      o_win_pc   <= RESET_PC;
      o_mem_addr <= {RESET_PC[31:2], 2'b00};
    end else if (i_redirect) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      skip       <= i_redirect_addr[1:0];
      o_win_pc   <= i_redirect_addr;
      o_mem_addr <= {i_redirect_addr[31:2], 2'b00};
    end else begin
      head     <= head + PW'(cons);
      tail     <= tail + PW'(acc_n);
      count    <= count_n;
      o_win_pc <= o_win_pc + 32'(cons);
      if (acc) begin
        o_mem_addr <= o_mem_addr + 32'd4;
        skip       <= 2'd0;
      end
    end
  always_ff @(posedge i_clk)
    for (int j = 0; j < 4; j++)
      if (acc && 2'(j) >= skip) q[tail + PW'(j) - PW'(skip)] <= i_mem_data[8*j +: 8];
  always_comb begin
    o_window = '0;
    for (int i = 0; i < WIN_BYTES; i++)
      if (CW'(i) < count) o_window[8*i +: 8] = q[head + PW'(i)];
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: scoreboard bench against a byte-queue reference model
module tb_instr_prefetch_queue;
  logic        clk = 0, rst_n = 0;
  logic        mem_req, mem_ack = 0, redirect = 0, consume = 0;
  logic [31:0] mem_addr, mem_data = 0, redirect_addr = 0, win_pc;
  logic [63:0] window;
  logic [3:0]  win_bytes, consume_bytes = 0;
  int          checks = 0, errors = 0;
  bit          mon_en = 1;
  typedef struct packed {
    logic [63:0] win;
    logic [3:0]  wb;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  bq[$];
  logic [31:0] m_pc, m_fa;
  logic [1:0]  m_sk;
  bit          m_req;

  instr_prefetch_queue #(.DEPTH_BYTES(16), .WIN_BYTES(8), .RESET_PC(32'h1000)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data), .i_redirect(redirect),
    .i_redirect_addr(redirect_addr), .o_window(window), .o_win_bytes(win_bytes),
    .o_win_pc(win_pc), .i_consume(consume), .i_consume_bytes(consume_bytes));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.win = '0;
    for (int i = 0; i < 8 && i < bq.size(); i++) e.win[8*i +: 8] = bq[i];
    e.wb   = 4'(bq.size() > 8 ? 8 : bq.size());
    e.pc   = m_pc;
    e.req  = m_req;
    e.addr = m_fa;
    return e;
  endfunction

  task automatic spot(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  task automatic cyc(input bit ack, input bit con, input logic [3:0] cb, input bit rd,
                     input logic [31:0] ra, input logic [31:0] d);
    int w, c;
    @(negedge clk);
    #1;
    mem_ack = ack; consume = con; consume_bytes = cb; redirect = rd; redirect_addr = ra; mem_data = d;
    if (rd) begin
      bq.delete();
      m_pc = ra; m_fa = {ra[31:2], 2'b00}; m_sk = ra[1:0]; m_req = 1;
    end else begin
      w = bq.size() > 8 ? 8 : bq.size();
      c = con ? (int'(cb) > w ? w : int'(cb)) : 0;
      repeat (c) void'(bq.pop_front());
      m_pc += 32'(c);
      if (m_req && ack) begin
        for (int j = int'(m_sk); j < 4; j++) bq.push_back(d[8*j +: 8]);
        m_fa += 32'd4;
        m_sk = 2'd0;
      end
      m_req = bq.size() <= 12;
    end
    exp_q.push_back(snap());
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk)
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 5;
      if (window !== e.win) begin errors++; $display("FAIL window: got %h expected %h", window, e.win); end
      if (win_bytes !== e.wb) begin errors++; $display("FAIL win_bytes: got %0d expected %0d", win_bytes, e.wb); end
      if (win_pc !== e.pc) begin errors++; $display("FAIL win_pc: got %h expected %h", win_pc, e.pc); end
      if (mem_req !== e.req) begin errors++; $display("FAIL mem_req: got %b expected %b", mem_req, e.req); end
      if (mem_addr !== e.addr) begin errors++; $display("FAIL mem_addr: got %h expected %h", mem_addr, e.addr); end
    end

  initial begin
    m_pc = 32'h1000; m_fa = 32'h1000; m_sk = 2'd0; m_req = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    exp_q.push_back(snap());
    spot("reset_req", 64'(mem_req), 64'd0);
    spot("reset_addr", 64'(mem_addr), 64'h1000);
    spot("reset_wb", 64'(win_bytes), 64'd0);
    spot("reset_pc", 64'(win_pc), 64'h1000);
    idle();
    cyc(1, 0, 0, 0, 0, 32'h04030201);
    cyc(1, 0, 0, 0, 0, 32'h08070605);
    idle();
    spot("t1_window", window, 64'h0807060504030201);
    spot("t1_wb", 64'(win_bytes), 64'd8);
    spot("t1_pc", 64'(win_pc), 64'h1000);
    cyc(1, 1, 8, 0, 0, 32'h0C0B0A09);
    idle();
    spot("t5_window", window, 64'h0C0B0A09);
    spot("t5_wb", 64'(win_bytes), 64'd4);
    spot("t5_pc", 64'(win_pc), 64'h1008);
    repeat (3) cyc(1, 0, 0, 0, 0, mem_word(m_fa));
    idle();
    spot("t3_full_req", 64'(mem_req), 64'd0);
    spot("t3_full_addr", 64'(mem_addr), 64'h1018);
    cyc(1, 1, 4, 0, 0, 32'hDEADBEEF);
    idle();
    spot("t3_refill_req", 64'(mem_req), 64'd1);
    cyc(1, 1, 3, 1, 32'h2002, 32'h11111111);
    idle();
    spot("t4_addr", 64'(mem_addr), 64'h2000);
    spot("t4_empty", 64'(win_bytes), 64'd0);
    cyc(1, 0, 0, 0, 0, 32'hDDCCBBAA);
    idle();
    spot("t4_window", window, 64'hDDCC);
    spot("t4_wb", 64'(win_bytes), 64'd2);
    spot("t4_pc", 64'(win_pc), 64'h2002);
    cyc(0, 1, 8, 0, 0, 0);
    idle();
    spot("t7_clip_wb", 64'(win_bytes), 64'd0);
    spot("t7_clip_pc", 64'(win_pc), 64'h2004);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 1) ? $urandom : (32'hFFFFFFF0 | 32'($urandom_range(0, 15)));
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, 4'($urandom_range(0, 8)),
          $urandom_range(0, 99) < 3, ra, mem_word(m_fa));
    end
    cyc(0, 0, 0, 1, 32'h3001, 0);
    idle();
    spot("t6_pre_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    #1 mon_en = 0;
    #1 rst_n = 0;
    #1;
    spot("t6_req", 64'(mem_req), 64'd0);
    spot("t6_wb", 64'(win_bytes), 64'd0);
    spot("t6_pc", 64'(win_pc), 64'h1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
